// File: rtl/mc_alu.sv
// Multi-cycle ALU: 1-cycle arithmetic/logic, iterative 1-bit-per-cycle shifter.
// Define MC_ALU_FAST_SHIFT_EN to replace the iterative shifter with a 1-cycle barrel shifter.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // SUB reuses the ADD adder as op1 + ~op2 + 1; carry-out then means no borrow.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~op2 : op2;
  assign sum    = {1'b0, op1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign shamt  = op2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_XOR:  alu_res = op1 ^ op2;
      OP_OR:   alu_res = op1 | op2;
      OP_AND:  alu_res = op1 & op2;
`ifdef MC_ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
`else
      // Only reached with shamt == 0; non-zero shifts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op1;
`endif
      default: alu_res = '0;
    endcase
  end

`ifndef MC_ALU_FAST_SHIFT_EN
  localparam logic [1:0] KIND_SLL = 2'd0;
  localparam logic [1:0] KIND_SRL = 2'd1;
  localparam logic [1:0] KIND_SRA = 2'd2;

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             is_shift;
  logic [WIDTH-1:0] step_res;

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    step_res = result_q;
    case (kind_q)
      KIND_SLL: step_res = {result_q[WIDTH-2:0], 1'b0};
      KIND_SRL: step_res = {1'b0, result_q[WIDTH-1:1]};
      KIND_SRA: step_res = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default:  step_res = result_q;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`ifndef MC_ALU_FAST_SHIFT_EN
    cnt_d    = cnt_q;
    kind_d   = kind_q;
`endif
    if (kill) begin
      state_d = IDLE;
`ifndef MC_ALU_FAST_SHIFT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_c;
            ovf_d    = alu_v;
`ifndef MC_ALU_FAST_SHIFT_EN
            if (is_shift && (shamt != '0)) begin
              // result_q doubles as the shift register while in SHIFT.
              state_d  = SHIFT;
              result_d = op1;
              zero_d   = 1'b0;
              cnt_d    = shamt;
              kind_d   = (op == OP_SLL) ? KIND_SLL :
                         (op == OP_SRL) ? KIND_SRL : KIND_SRA;
            end
`endif
          end
        end
`ifndef MC_ALU_FAST_SHIFT_EN
        SHIFT: begin
          result_d = step_res;
          cnt_d    = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d = DONE;
            zero_d  = (step_res == '0);
          end
        end
`endif
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifndef MC_ALU_FAST_SHIFT_EN
      cnt_q    <= '0;
      kind_q   <= KIND_SLL;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`ifndef MC_ALU_FAST_SHIFT_EN
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu: WIDTH=32 instance driven through a scoreboard, plus a WIDTH=8 instance.
module tb_mc_alu;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kill, in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] op1, op2;
  logic        in_ready, out_valid, zero, carry, ovf;
  logic [31:0] result;

  logic        in_valid8, out_ready8, kill8;
  logic [3:0]  op8;
  logic [7:0]  op1_8, op2_8;
  logic        in_ready8, out_valid8, zero8, carry8, ovf8;
  logic [7:0]  result8;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf)
  );

  mc_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .kill(kill8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .op1(op1_8), .op2(op2_8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .carry(carry8), .ovf(ovf8)
  );

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] w;
    logic [4:0]  s;
    s = b[4:0];
    e = '0;
    case (o)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        e.r = w[31:0];
        e.c = w[32];
        e.v = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      4'd1: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      4'd2: e.r = a << s;
      4'd3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: e.r = (a < b) ? 32'd1 : 32'd0;
      4'd5: e.r = a ^ b;
      4'd6: e.r = a >> s;
      4'd7: e.r = $unsigned($signed(a) >>> s);
      4'd8: e.r = a | b;
      4'd9: e.r = a & b;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [31:0] b);
    int l;
    l = 1;
`ifndef MC_ALU_FAST_SHIFT_EN
    if ((o == 4'd2 || o == 4'd6 || o == 4'd7) && b[4:0] != 5'd0) l = 1 + int'(b[4:0]);
`endif
    return l;
  endfunction

  // Pops the scoreboard against the presented result, then consumes it.
  task automatic collect(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard empty when output checked", name);
      e = '0;
    end else e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid got %b want 1", name, out_valid);
    end
    checks++;
    if (result !== e.r) begin
      errors++; $display("FAIL %s result got %h want %h", name, result, e.r);
    end
    checks++;
    if ({zero, carry, ovf} !== {e.z, e.c, e.v}) begin
      errors++; $display("FAIL %s flags zco got %b%b%b want %b%b%b", name, zero, carry, ovf, e.z, e.c, e.v);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s after consume in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input string name);
    int lat, want_lat;
    want_lat = exp_lat(o, b);
    exp_q.push_back(e);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready got %b want 1 before accept", name, in_ready);
    end
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != want_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, want_lat);
    end
    collect(name);
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset in_ready/out_valid got %b/%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL reset result got %h want 0", result);
    end
    checks++;
    if ({zero, carry, ovf} !== 3'b000) begin
      errors++; $display("FAIL reset flags got %b%b%b want 000", zero, carry, ovf);
    end
  endtask

  task automatic test_arith;
    run_op(4'd0, 32'hFFFFFFFF, 32'h1, '{32'h0, 1'b1, 1'b1, 1'b0}, "add_wrap");
    run_op(4'd0, 32'h7FFFFFFF, 32'h1, '{32'h80000000, 1'b0, 1'b0, 1'b1}, "add_ovf");
    run_op(4'd1, 32'h80000000, 32'h1, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b1}, "sub_ovf");
    run_op(4'd1, 32'd5, 32'd7, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}, "sub_borrow");
    run_op(4'd3, 32'hFFFFFFFF, 32'h1, '{32'h1, 1'b0, 1'b0, 1'b0}, "slt");
    run_op(4'd4, 32'hFFFFFFFF, 32'h1, '{32'h0, 1'b1, 1'b0, 1'b0}, "sltu");
    run_op(4'd5, 32'hF0F0F0F0, 32'hFF00FF00, '{32'h0FF00FF0, 1'b0, 1'b0, 1'b0}, "xor");
    run_op(4'd8, 32'h12340000, 32'h00005678, '{32'h12345678, 1'b0, 1'b0, 1'b0}, "or");
    run_op(4'd9, 32'hFF00FF00, 32'h0F0F0F0F, '{32'h0F000F00, 1'b0, 1'b0, 1'b0}, "and");
    run_op(4'd12, 32'd5, 32'd7, '{32'h0, 1'b1, 1'b0, 1'b0}, "reserved");
  endtask

  task automatic test_shift;
    run_op(4'd7, 32'h80000000, 32'd31, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, "sra31");
    run_op(4'd7, 32'h80000000, 32'd0, '{32'h80000000, 1'b0, 1'b0, 1'b0}, "sra0");
    run_op(4'd2, 32'h1, 32'h25, '{32'h20, 1'b0, 1'b0, 1'b0}, "sll5");
    run_op(4'd6, 32'h80000000, 32'd31, '{32'h1, 1'b0, 1'b0, 1'b0}, "srl31");
    run_op(4'd7, 32'h40000000, 32'd4, '{32'h04000000, 1'b0, 1'b0, 1'b0}, "sra_pos");
    run_op(4'd2, 32'h80000000, 32'd1, '{32'h0, 1'b1, 1'b0, 1'b0}, "sll_zero");
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      run_op(o, a, b, model(o, a, b), "random");
    end
  endtask

  task automatic test_backpressure;
    exp_q.push_back('{32'd30, 1'b0, 1'b0, 1'b0});
    op = 4'd0; op1 = 32'd10; op2 = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd1; op1 = 32'd50; op2 = 32'd8;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30 || {zero, carry, ovf} !== 3'b000) begin
        errors++; $display("FAIL stall cycle %0d vld=%b rdy=%b res=%h zco=%b%b%b want 1/0/1e/000",
                           i, out_valid, in_ready, result, zero, carry, ovf);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL no_accept_on_consume vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    exp_q.push_back('{32'd42, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("second_after_stall");
  endtask

  task automatic test_kill;
    int seen;
    seen = 0;
    op = 4'd2; op1 = 32'h1; op2 = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
`ifndef MC_ALU_FAST_SHIFT_EN
      if (out_valid === 1'b1) seen++;
`endif
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL kill_idle rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 25; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL kill_no_output out_valid seen %0d times want 0", seen);
    end
    // kill beats a simultaneous accept
    kill = 1'b1; in_valid = 1'b1; op = 4'd0; op1 = 32'd1; op2 = 32'd1;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL kill_vs_accept rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    run_op(4'd0, 32'd2, 32'd3, '{32'd5, 1'b0, 1'b0, 1'b0}, "add_after_kill");
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    op = 4'd6; op1 = 32'hFFFF0000; op2 = 32'd25; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || {zero, carry, ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_mid vld=%b rdy=%b res=%h zco=%b%b%b want 0/1/0/000",
                         out_valid, in_ready, result, zero, carry, ovf);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release out_valid seen %0d in_ready=%b want 0/1", seen, in_ready);
    end
  endtask

  task automatic test_width8;
    int lat;
    op8 = 4'd0; op1_8 = 8'h7F; op2_8 = 8'h01; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1 || result8 !== 8'h80 || {zero8, carry8, ovf8} !== 3'b001) begin
      errors++; $display("FAIL w8_add vld=%b res=%h zco=%b%b%b want 1/80/001", out_valid8, result8, zero8, carry8, ovf8);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    op8 = 4'd7; op1_8 = 8'h80; op2_8 = 8'h07; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
`ifdef MC_ALU_FAST_SHIFT_EN
    if (lat != 1 || result8 !== 8'hFF) begin
      errors++; $display("FAIL w8_sra lat=%0d res=%h want 1/ff", lat, result8);
    end
`else
    if (lat != 8 || result8 !== 8'hFF) begin
      errors++; $display("FAIL w8_sra lat=%0d res=%h want 8/ff", lat, result8);
    end
`endif
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; op1 = 32'd0; op2 = 32'd0;
    kill8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    op8 = 4'd0; op1_8 = 8'd0; op2_8 = 8'd0;
    #1;
    test_reset;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_arith;
    test_shift;
    test_random;
    test_backpressure;
    test_kill;
    test_reset_mid;
    test_width8;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits; power of two, 8..64.
REQ-002 SHALL have derived localparam: SHW, $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port: kill  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port: in_valid  input  1  operation request.
REQ-007 SHALL have port: in_ready  output  1  block can accept a request.
REQ-008 SHALL have port: op  input  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 reserved.
REQ-009 SHALL have port: op1  input  WIDTH  first operand.
REQ-010 SHALL have port: op2  input  WIDTH  second operand; shifts use op2[SHW-1:0] as shamt.
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.
REQ-013 SHALL have port: result  output  WIDTH  registered result.
REQ-014 SHALL have port: zero  output  1  result == 0.
REQ-015 SHALL have port: carry  output  1  ADD carry-out; SUB no-borrow (op1 >= op2 unsigned); 0 for other ops.
REQ-016 SHALL have port: ovf  output  1  signed overflow for ADD/SUB; 0 for other ops.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE), combinational.
REQ-018 SHALL accept a request on a rising edge with in_valid && in_ready, capturing op, op1, op2.
REQ-019 SHALL, for non-shift ops, compute the result at the accept edge and enter DONE, giving latency 1.
REQ-020 SHALL compute SUB as op1 + ~op2 + 1 in a WIDTH+1-bit adder shared with ADD; results wrap modulo 2^WIDTH.
REQ-021 SHALL return 1 or 0, zero-extended, for SLT (signed) and SLTU (unsigned).
REQ-022 SHALL, for a shift with shamt == 0, enter DONE at the accept edge with result = op1 and latency 1.
REQ-023 SHALL, for a shift with shamt > 0, load op1 and a counter = shamt, enter SHIFT, and shift by one bit per edge; SRA replicates the MSB, SLL/SRL fill with 0.
REQ-024 SHALL enter DONE on the edge where the counter reaches 0, giving latency 1 + shamt edges from accept to out_valid.
REQ-025 SHALL hold out_valid = 1 in DONE, with result and flags stable until an edge with out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-026 SHALL NOT accept a request in the same cycle a result is consumed; minimum initiation interval is 2 cycles.
REQ-027 SHALL return to IDLE on an edge with kill = 1 from any state, drop out_valid, and discard the operation.
REQ-028 SHALL give kill priority over a simultaneous accept or consume.
REQ-029 SHALL treat reserved opcodes as 1-cycle ops with result 0, zero 1, carry 0, ovf 0.
REQ-030 SHALL register zero, carry and ovf together with result.

Reset
REQ-031 SHALL, while reset_n = 0, immediately force state IDLE, out_valid 0, result 0, zero 0, carry 0, ovf 0, counter 0, and in_ready 1.
REQ-032 SHALL abandon any in-flight operation on reset assertion mid-operation, with no result produced after release.

Configuration
REQ-033 SHALL, when MC_ALU_FAST_SHIFT_EN is defined, implement all shifts as a single-cycle barrel shifter with latency 1, never entering SHIFT.
REQ-034 SHALL, when MC_ALU_FAST_SHIFT_EN is undefined, implement shifts iteratively per REQ-023/024; results SHALL be identical in both builds.

Verification
REQ-035 SHALL cover: WIDTH=32, ADD 0xFFFFFFFF + 0x1 -> result 0x0, zero 1, carry 1, ovf 0, out_valid 1 cycle after accept.
REQ-036 SHALL cover: SUB 0x80000000 - 0x1 -> result 0x7FFFFFFF, carry 1, ovf 1; SLT 0xFFFFFFFF vs 0x1 -> 1; SLTU same operands -> 0.
REQ-037 SHALL cover: SRA op1 0x80000000, shamt 31 -> result 0xFFFFFFFF, out_valid 32 edges after accept (iterative build) or 1 edge (fast build); shamt 0 -> 0x80000000 after 1 edge.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result and flags stable, in_ready 0; with in_valid held 1 the next accept occurs only after consume.
REQ-039 SHALL cover: kill asserted 3 edges into an SLL by 20 -> IDLE next edge, out_valid never asserted, the next ADD 2 + 3 -> 5.
REQ-040 SHALL cover: reset_n dropped mid-SRL, then released -> out_valid 0, result 0, in_ready 1; WIDTH=8 build with ADD 0x7F + 0x01 -> 0x80, ovf 1.
